// File: rtl/ntt_ct_butterfly.sv
// Cooley-Tukey forward NTT butterfly, q = 12289, Montgomery R = 2^18.
// Optional S6 conditional subtraction of 2q enabled by NTT_CT_CORRECT_EN.
module ntt_ct_butterfly (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] a,
   input  logic [15:0] a_pair,
   input  logic [15:0] omega,
   output logic [15:0] b,
   output logic [15:0] b_pair,
   output logic        valid
);

   localparam logic [31:0] Q    = 32'd12289;
   localparam logic [15:0] Q3   = 16'd36867;
   localparam logic [17:0] QINV = 18'd12287;

   logic [31:0] p1, p2, p3;
   logic [17:0] u2;
   logic [31:0] uq3;
   logic [15:0] t4;
   logic [15:0] a1, a2, a3, a4;
   logic [15:0] b5, bp5;
   logic        v1, v2, v3, v4, v5;

   logic [31:0] p_next;
   logic [17:0] u_next;
   logic [31:0] uq_next;
   logic [32:0] sum;
   logic [15:0] t_next;
   logic [15:0] b_next;
   logic [15:0] bp_next;

   always_comb begin
      p_next  = {16'd0, a_pair} * {16'd0, omega};
      u_next  = p1[17:0] * QINV;
      uq_next = {14'd0, u2} * Q;
      sum     = {1'b0, p3} + {1'b0, uq3};
      t_next  = 16'(sum >> 18);
      b_next  = a4 + t4;
      bp_next = a4 + Q3 - t4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p1  <= '0;
         p2  <= '0;
         p3  <= '0;
         u2  <= '0;
         uq3 <= '0;
         t4  <= '0;
         a1  <= '0;
         a2  <= '0;
         a3  <= '0;
         a4  <= '0;
         b5  <= '0;
         bp5 <= '0;
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         v4  <= 1'b0;
         v5  <= 1'b0;
      end else if (en) begin
         p1  <= p_next;
         a1  <= a;
         v1  <= load;
         u2  <= u_next;
         p2  <= p1;
         a2  <= a1;
         v2  <= v1;
         uq3 <= uq_next;
         p3  <= p2;
         a3  <= a2;
         v3  <= v2;
         t4  <= t_next;
         a4  <= a3;
         v4  <= v3;
         b5  <= b_next;
         bp5 <= bp_next;
         v5  <= v4;
      end
   end

`ifdef NTT_CT_CORRECT_EN
   localparam logic [15:0] Q2 = 16'd24578;

   logic [15:0] b6, bp6;
   logic        v6;
   logic [15:0] b_corr, bp_corr;

   always_comb begin
      b_corr  = (b5 >= Q2) ? b5 - Q2 : b5;
      bp_corr = (bp5 >= Q2) ? bp5 - Q2 : bp5;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         b6  <= '0;
         bp6 <= '0;
         v6  <= 1'b0;
      end else if (en) begin
         b6  <= b_corr;
         bp6 <= bp_corr;
         v6  <= v5;
      end
   end

   assign b      = b6;
   assign b_pair = bp6;
   assign valid  = v6;
`else
   assign b      = b5;
   assign b_pair = bp5;
   assign valid  = v5;
`endif

endmodule

// File: tb/tb_ntt_ct_butterfly.sv
// Directed bench for ntt_ct_butterfly; follows NTT_CT_CORRECT_EN for
// latency and corrected expected values.
module tb_ntt_ct_butterfly;

`ifdef NTT_CT_CORRECT_EN
   localparam int LAT = 6;
   localparam logic [15:0] BP_ZERO = 16'd12389;
   localparam logic [15:0] BP_RAW  = 16'd11713;
   localparam logic [15:0] BP_ONE  = 16'd12294;
`else
   localparam int LAT = 5;
   localparam logic [15:0] BP_ZERO = 16'd36967;
   localparam logic [15:0] BP_RAW  = 16'd36291;
   localparam logic [15:0] BP_ONE  = 16'd36872;
`endif

   logic        clk = 1'b0;
   logic        reset, en, load;
   logic [15:0] a, a_pair, omega;
   logic [15:0] b, b_pair;
   logic        valid;

   int n_run  = 0;
   int n_fail = 0;

   ntt_ct_butterfly dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .load   (load),
      .a      (a),
      .a_pair (a_pair),
      .omega  (omega),
      .b      (b),
      .b_pair (b_pair),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [15:0] x, input logic [15:0] xp,
                        input logic [15:0] w);
      a      = x;
      a_pair = xp;
      omega  = w;
      load   = 1'b1;
      step();
      load   = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] eb,
                             input logic [15:0] ebp);
      check({tag, "_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_b"}, {16'd0, b}, {16'd0, eb});
      check({tag, "_bp"}, {16'd0, b_pair}, {16'd0, ebp});
   endtask

   initial begin
      int seen;
      reset  = 1'b1;
      en     = 1'b0;
      load   = 1'b1;
      a      = 16'd1234;
      a_pair = 16'd55;
      omega  = 16'd99;
      step();
      step();
      check("rst_b", {16'd0, b}, 32'd0);
      check("rst_bp", {16'd0, b_pair}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);

      // load that coincided with reset must never emerge
      reset = 1'b0;
      load  = 1'b0;
      en    = 1'b1;
      seen  = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         if (valid) seen++;
      end
      check("rst_load_drop", seen, 0);

      // zero twiddle
      issue(16'd100, 16'd777, 16'd0);
      for (int i = 0; i < LAT - 1; i++) begin
         step();
         if (i < LAT - 2) check("zero_early", {31'd0, valid}, 32'd0);
      end
      expect_out("zero", 16'd100, BP_ZERO);
      step();
      check("zero_drop", {31'd0, valid}, 32'd0);

      // raw Montgomery and Montgomery one, individually
      issue(16'd0, 16'd1, 16'd1);
      for (int i = 0; i < LAT - 1; i++) step();
      expect_out("raw", 16'd576, BP_RAW);
      issue(16'd10, 16'd5, 16'd4075);
      for (int i = 0; i < LAT - 1; i++) step();
      expect_out("one", 16'd15, BP_ONE);
      step();

      // streaming back-to-back
      issue(16'd100, 16'd777, 16'd0);
      issue(16'd0, 16'd1, 16'd1);
      issue(16'd10, 16'd5, 16'd4075);
      for (int i = 0; i < LAT - 3; i++) step();
      expect_out("str0", 16'd100, BP_ZERO);
      step();
      expect_out("str1", 16'd576, BP_RAW);
      step();
      expect_out("str2", 16'd15, BP_ONE);
      step();
      check("str_drop", {31'd0, valid}, 32'd0);

      // stall while operand sits in S3
      issue(16'd10, 16'd5, 16'd4075);
      step();
      step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_mid_valid", {31'd0, valid}, 32'd0);
      end
      en = 1'b1;
      for (int i = 0; i < LAT - 3; i++) begin
         step();
         if (i < LAT - 4) check("stall_early", {31'd0, valid}, 32'd0);
      end
      expect_out("stall_out", 16'd15, BP_ONE);

      // stall while valid is high
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("hold", 16'd15, BP_ONE);
      end
      en = 1'b1;
      step();
      check("hold_drop", {31'd0, valid}, 32'd0);

      // reset mid-flight
      issue(16'd100, 16'd777, 16'd0);
      issue(16'd10, 16'd5, 16'd4075);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("flush_b", {16'd0, b}, 32'd0);
      check("flush_bp", {16'd0, b_pair}, 32'd0);
      check("flush_valid", {31'd0, valid}, 32'd0);
      seen = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         if (valid) seen++;
      end
      check("flush_none", seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
